// File: rtl/cronometro_controle_if.sv
// rtl/cronometro_controle_if.sv - panel/counter-bank signal bundle for the stopwatch controller
interface cronometro_controle_if #(
  parameter int DIGITS = 2
);
  logic                start;
  logic                stop;
  logic                clear;
  logic [4*DIGITS-1:0] target;
  logic [4*DIGITS-1:0] q;
  logic [DIGITS-1:0]   en;
  logic                clr;
  logic                tick;
  logic                running;
  logic                done;

  // Panel and counter bank side: drives commands and the digit readback.
  modport master (
    output start, stop, clear, target, q,
    input  en, clr, tick, running, done
  );

  // Controller side.
  modport slave (
    input  start, stop, clear, target, q,
    output en, clr, tick, running, done
  );
endinterface

// File: rtl/cronometro_controle.sv
// rtl/cronometro_controle.sv - run/pause/clear controller for a cascade of BCD digit counters
module cronometro_controle #(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 4
) (
  input logic                  clock,
  input logic                  reset,
  cronometro_controle_if.slave ctl
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [PW-1:0]     pre;
  logic              clr_pend;
  logic              hit;
  logic              tick_int;
  logic [DIGITS-1:0] en_int;

  // Full-width compare: a target digit above 9 can never match, so counting never ends.
  assign hit      = (ctl.q == ctl.target);
  assign tick_int = (state == S_RUN) && (pre == PRE_LAST);

  // Decimal carry chain: a digit counts when all lower digits are at 9 on a tick.
  always_comb begin
    en_int    = '0;
    en_int[0] = tick_int & ~hit;
    for (int i = 1; i < DIGITS; i++) begin
      en_int[i] = en_int[i-1] & (ctl.q[4*(i-1) +: 4] == 4'd9);
    end
  end

  assign ctl.en   = en_int;
  assign ctl.tick = tick_int;

  // Next-state selection; clear beats stop, stop beats start.
  always_comb begin
    state_nxt = state;
    if (ctl.clear) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (!ctl.stop && ctl.start) begin
            state_nxt = hit ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (ctl.stop) begin
            state_nxt = S_PAUSE;
          end else if (hit) begin
            state_nxt = S_DONE;
          end
        end
        S_PAUSE: begin
          if (!ctl.stop && ctl.start) begin
            state_nxt = S_RUN;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // State, prescaler and registered outputs; clr_pend forces one clr pulse after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      pre         <= '0;
      clr_pend    <= 1'b1;
      ctl.clr     <= 1'b0;
      ctl.running <= 1'b0;
      ctl.done    <= 1'b0;
    end else begin
      state       <= state_nxt;
      clr_pend    <= 1'b0;
      ctl.clr     <= ctl.clear | clr_pend;
      ctl.running <= (state_nxt == S_RUN);
      ctl.done    <= (state_nxt == S_DONE);
      if (ctl.clear || (state == S_IDLE && state_nxt == S_RUN)) begin
        pre <= '0;
      end else if (state == S_RUN) begin
        pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cronometro_controle.sv
// tb/tb_cronometro_controle.sv - directed and randomized bench for cronometro_controle
module tb_cronometro_controle;

  localparam int D = 2;
  localparam int P = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic clock = 1'b0;
  logic reset;

  cronometro_controle_if #(.DIGITS(D)) ctl ();

  cronometro_controle #(.DIGITS(D), .PRESCALE(P)) dut (
    .clock (clock),
    .reset (reset),
    .ctl   (ctl)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ticks = 0;

  int m_state;
  int m_pre;
  int m_q;
  bit m_clr;
  bit m_pend;

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic exp_tick();
    return (m_state == M_RUN) && (m_pre == P - 1);
  endfunction

  function automatic logic [D-1:0] exp_en();
    logic [D-1:0] r = '0;
    if (exp_tick() && (to_bcd(m_q) != ctl.target)) begin
      for (int i = 0; i < D; i++) r[i] = ((m_q % p10(i)) == p10(i) - 1);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit hit;
    bit nclr;
    hit = (to_bcd(m_q) == ctl.target);
    if (reset) begin
      m_state = M_IDLE;
      m_pre   = 0;
      m_clr   = 1'b0;
      m_pend  = 1'b1;
    end else begin
      nclr   = ctl.clear | m_pend;
      m_pend = 1'b0;
      if (ctl.clear) begin
        m_state = M_IDLE;
        m_pre   = 0;
      end else if (m_state == M_IDLE) begin
        if (!ctl.stop && ctl.start) begin
          m_pre   = 0;
          m_state = hit ? M_DONE : M_RUN;
        end
      end else if (m_state == M_RUN) begin
        m_pre = (m_pre + 1) % P;
        if (ctl.stop) m_state = M_PAUSE;
        else if (hit) m_state = M_DONE;
      end else if (m_state == M_PAUSE) begin
        if (!ctl.stop && ctl.start) m_state = M_RUN;
      end
      m_clr = nclr;
    end
  endtask

  task automatic peek();
    ctl.q = to_bcd(m_q);
    #1;
  endtask

  task automatic step();
    logic [D-1:0] e_en;
    logic         e_tick;
    int           q_next;
    ctl.q = to_bcd(m_q);
    #1;
    e_tick = exp_tick();
    e_en   = exp_en();
    check("en",      32'(ctl.en),      32'(e_en));
    check("tick",    32'(ctl.tick),    32'(e_tick));
    check("clr",     32'(ctl.clr),     32'(m_clr));
    check("running", 32'(ctl.running), 32'(m_state == M_RUN));
    check("done",    32'(ctl.done),    32'(m_state == M_DONE));
    if (e_tick) n_ticks++;
    q_next = m_clr ? 0 : (e_en[0] ? (m_q + 1) % p10(D) : m_q);
    @(posedge clock);
    model_update();
    m_q = q_next;
    @(negedge clock);
  endtask

  initial begin
    int n;
    int r;
    logic [4*D-1:0] t;

    reset      = 1'b1;
    ctl.start  = 1'b0;
    ctl.stop   = 1'b0;
    ctl.clear  = 1'b0;
    ctl.target = 8'h25;
    m_q        = 37;
    ctl.q      = to_bcd(m_q);
    @(posedge clock);
    @(negedge clock);
    m_state = M_IDLE;
    m_pre   = 0;
    m_clr   = 1'b0;
    m_pend  = 1'b1;

    // reset held two cycles, then a single clr pulse
    step();
    step();
    reset = 1'b0;
    step();
    peek();
    check("clr_after_reset", 32'(ctl.clr), 32'd1);
    check("idle_after_reset", 32'(ctl.running | ctl.done), 32'd0);
    step();
    peek();
    check("clr_one_cycle", 32'(ctl.clr), 32'd0);

    // count 00 -> 25 with a carry at 09
    ctl.target = 8'h25;
    ctl.start  = 1'b1;
    step();
    ctl.start  = 1'b0;
    n_ticks = 0;
    n = 0;
    while (m_q != 25 && n < 200) begin
      if (m_q == 9 && exp_tick()) begin
        peek();
        check("carry09", 32'(ctl.en), 32'h3);
      end
      step();
      n++;
    end
    check("cycles_to_25", 32'(n >= 99 && n <= 101), 32'd1);
    check("ticks_to_25", 32'(n_ticks), 32'd25);
    peek();
    check("en_at_target", 32'(ctl.en), 32'd0);
    step();
    peek();
    check("done_at_25", 32'(ctl.done), 32'd1);
    step();

    // pause at q=03 with prescaler held at 2, then resume
    ctl.clear = 1'b1;
    step();
    ctl.clear = 1'b0;
    step();
    ctl.target = 8'h50;
    ctl.start  = 1'b1;
    step();
    ctl.start  = 1'b0;
    n = 0;
    while (!(m_q == 3 && m_pre == 1 && m_state == M_RUN) && n < 100) begin
      step();
      n++;
    end
    check("timeout_pause", 32'(n < 100), 32'd1);
    ctl.stop = 1'b1;
    repeat (10) begin
      peek();
      check("pause_en", 32'(ctl.en), 32'd0);
      step();
    end
    ctl.stop  = 1'b0;
    ctl.start = 1'b1;
    step();
    ctl.start = 1'b0;
    peek();
    check("resume_tick0", 32'(ctl.tick), 32'd0);
    step();
    peek();
    check("resume_tick1", 32'(ctl.tick), 32'd1);
    step();

    // clear beats stop and start
    repeat ($urandom_range(3, 9)) step();
    ctl.clear = 1'b1;
    ctl.stop  = 1'b1;
    ctl.start = 1'b1;
    step();
    ctl.clear = 1'b0;
    ctl.stop  = 1'b0;
    ctl.start = 1'b0;
    peek();
    check("cp_running", 32'(ctl.running), 32'd0);
    check("cp_clr", 32'(ctl.clr), 32'd1);
    ctl.start = 1'b1;
    step();
    ctl.start = 1'b0;
    n = 0;
    while (n < 10) begin
      peek();
      if (ctl.tick === 1'b1) break;
      step();
      n++;
    end
    check("cp_first_tick", 32'(n), 32'(P - 1));

    // target 00 with q=00: straight to DONE
    ctl.clear = 1'b1;
    step();
    ctl.clear = 1'b0;
    step();
    ctl.target = 8'h00;
    ctl.start  = 1'b1;
    peek();
    check("t00_en", 32'(ctl.en), 32'd0);
    step();
    ctl.start = 1'b0;
    peek();
    check("t00_done", 32'(ctl.done), 32'd1);
    check("t00_running", 32'(ctl.running), 32'd0);
    step();

    // unreachable target: 99 wraps to 00 and counting continues
    ctl.clear = 1'b1;
    step();
    ctl.clear = 1'b0;
    step();
    ctl.target = 8'hA0;
    ctl.start  = 1'b1;
    step();
    ctl.start  = 1'b0;
    n = 0;
    while (!(m_q == 99 && exp_tick()) && n < 600) begin
      step();
      n++;
    end
    check("timeout_wrap", 32'(n < 600), 32'd1);
    peek();
    check("wrap_en", 32'(ctl.en), 32'h3);
    step();
    peek();
    check("wrap_done", 32'(ctl.done), 32'd0);
    check("wrap_running", 32'(ctl.running), 32'd1);
    repeat (8) step();

    // randomized commands and targets against the model
    repeat (400) begin
      r = $urandom_range(0, 99);
      ctl.start = (r < 12);
      ctl.stop  = (r >= 12 && r < 18);
      ctl.clear = (r >= 18 && r < 21);
      if (r >= 97) begin
        t = to_bcd($urandom_range(0, 99));
        if (r == 99) t[7:4] = 4'(10 + $urandom_range(0, 5));
        ctl.target = t;
      end
      step();
    end
    ctl.start = 1'b0;
    ctl.stop  = 1'b0;
    ctl.clear = 1'b0;

    // reset mid-run at q=47
    ctl.clear = 1'b1;
    step();
    ctl.clear = 1'b0;
    step();
    ctl.target = 8'h90;
    ctl.start  = 1'b1;
    step();
    ctl.start  = 1'b0;
    n = 0;
    while (m_q != 47 && n < 300) begin
      step();
      n++;
    end
    check("timeout_47", 32'(n < 300), 32'd1);
    reset = 1'b1;
    step();
    peek();
    check("rst_en", 32'(ctl.en), 32'd0);
    check("rst_running", 32'(ctl.running), 32'd0);
    check("rst_tick", 32'(ctl.tick), 32'd0);
    step();
    reset = 1'b0;
    step();
    peek();
    check("rst_clr", 32'(ctl.clr), 32'd1);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cronometro_controle.md
# cronometro_controle

Run/pause/clear controller for a cascade of external synchronous mod-10 (BCD) digit counters. It generates a prescaled count tick, the per-digit count enables with the decimal carry chain, and a digit-clear pulse. It stops the count when the digits reach a programmable BCD target. It sits between the front-panel push-button logic and the digit counter bank, and reads the counter outputs back for carry and compare.

## Interface
- `DIGITS`, default 2: number of cascaded BCD digits; ≥1.
- `PRESCALE`, default 4: clock cycles per count tick; ≥1.
- `clock`, input, 1: single system clock; rising edge.
- `reset`, input, 1: synchronous, active-high; sampled on `clock` rising edge.
- `start`, input, 1: level; begin or resume counting.
- `stop`, input, 1: level; pause counting.
- `clear`, input, 1: level; abort, clear digits, return to idle.
- `target`, input, 4*DIGITS: BCD stop value; digit 0 in bits [3:0].
- `q`, input, 4*DIGITS: current BCD value read back from the digit counters; same packing as `target`.
- `en`, output, DIGITS: per-digit count enable; the counter increments on the edge where its bit is 1.
- `clr`, output, 1: one-cycle clear pulse to all digit counters.
- `tick`, output, 1: prescaler tick; 1 for one cycle every PRESCALE cycles while running.
- `running`, output, 1: 1 in RUN.
- `done`, output, 1: 1 in DONE.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Encoding is free.
- Per-cycle input priority: `clear` > `stop` > `start`.
- IDLE:
  - `start` with q≠target: go to RUN and zero the prescaler.
  - `start` with q==target: go directly to DONE.
- RUN:
  - `stop`: go to PAUSE.
  - q==target: go to DONE.
- PAUSE:
  - `start`: go to RUN. The prescaler resumes from its held value; it is not zeroed.
- DONE:
  - `start` and `stop` are ignored.
- `clear` in any state: go to IDLE, zero the prescaler, and pulse `clr`.
- Prescaler, 0..PRESCALE-1:
  - Advances only in RUN and holds in every other state.
  - `tick` = 1 in the cycle where the prescaler equals PRESCALE-1 and the state is RUN.
  - The prescaler wraps to 0 on the edge after `tick`.
- Enables (combinational from the state, the prescaler and `q`):
  - `en[0]` = tick & (q≠target).
  - `en[i]` = `en[i-1]` & (q digit i-1 == 9).
  - The counters handle the 9→0 wrap themselves. An all-9s value plus a tick wraps to all-0s; the controller does not flag overflow.
- Compare: `target` and `q` are compared across all 4*DIGITS bits. A target digit above 9 is never matched, so counting runs indefinitely, which is legal.
- `target` changes take effect in the same cycle (combinational compare).

## Timing
- Reset values: state=IDLE, prescaler=0, `en`=0, `tick`=0, `running`=0, `done`=0.
- `clr`=1 in the cycle after `reset` deasserts, so the digit counters start from 00.
- `running` and `done` are registered state decodes. They change on the edge that takes the state transition.
- `clr` is registered: 1 for exactly the one cycle after the edge that samples `clear`. A `clear` held for N cycles gives N cycles of `clr`.
- Start latency:
  - `start` sampled at edge k gives RUN from edge k.
  - The first `tick` is at cycle k+PRESCALE-1, counting the cycle after edge k as cycle k.
  - The digit increments at the next edge after that cycle.
- Stop: the state changes at the edge that samples `stop`. A `tick` in the same cycle as `stop` still produces its enables (combinational) and its count.
- Target hit:
  - In the cycle where q==target, `en` is forced to 0.
  - DONE is reached on the next edge and `done`=1 from then on.
- Reset has priority over all inputs in every state, mid-count or mid-`clr` included.

## Test plan
- Reset, DIGITS=2, PRESCALE=4:
  - Hold `reset` 2 cycles.
  - Required: all outputs 0 during reset, `clr`=1 for 1 cycle after release, then IDLE.
- Count with carry, PRESCALE=4, target=8'h25, `start` pulsed with the bench model going from q=00:
  - `tick` every 4th cycle.
  - At q=09, `en`=2'b11 on the tick; q goes to 10.
  - At q=25, `en`=0 and `done`=1 one cycle later.
  - Total 25 ticks, 100 cycles ±1.
- Pause and resume: start, stop at q=03 with the prescaler at 2, hold stop 10 cycles, then start.
  - Required: no `en` during the pause.
  - The next tick comes 1 cycle after resume, because the prescaler resumes from 2.
- Clear priority: in RUN, assert `clear`, `stop` and `start` together.
  - Required: IDLE, `clr`=1 next cycle, `running`=0.
  - Then `start` gives the first tick PRESCALE-1 cycles later.
- Boundary compares:
  - target=8'h00 with q=00, then `start`: required DONE directly, zero `en`.
  - target=8'hA0: required q counts 99→00 with `en`=2'b11 on that tick and no DONE.
- Reset mid-run at q=47: required IDLE, `en`=0 immediately, `clr` pulse after release.
